// File: rtl/music_score_player.sv
// Score sequencer for the Pong sound path: walks the score RAM and holds each
// entry's key on KeyOut for its duration in beats, then loops or stops.
module music_score_player #(
  parameter int unsigned DataLength  = 4,
  parameter int unsigned AddressBits = 5,
  parameter int unsigned ScoreLength = 3,
  parameter int unsigned BeatTicks   = 25000000,
  parameter int unsigned TickBits    = 25
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Loop,
  output logic                   ReadOrWrite,
  output logic [AddressBits-1:0] Address,
  input  logic [DataLength-1:0]  KeyIn,
  input  logic [DataLength-1:0]  TimeIn,
  output logic [DataLength-1:0]  KeyOut,
  output logic                   Playing,
  output logic                   NoteStart,
  output logic                   ScoreDone
);

  localparam logic [AddressBits-1:0] LastAddr = AddressBits'(ScoreLength - 1);
  localparam logic [TickBits-1:0]    LastTick = TickBits'(BeatTicks - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_PLAY  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [AddressBits-1:0] addr_q, addr_d;
  logic [DataLength-1:0]  key_q, key_d;
  logic [DataLength-1:0]  beats_q, beats_d;
  logic [TickBits-1:0]    ticks_q, ticks_d;
  logic                   note_start_q, note_start_d;
  logic                   score_done_q, score_done_d;
  logic                   playing_q;
  logic                   advance;

  // State and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      key_q        <= '0;
      beats_q      <= '0;
      ticks_q      <= '0;
      note_start_q <= 1'b0;
      score_done_q <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      key_q        <= key_d;
      beats_q      <= beats_d;
      ticks_q      <= ticks_d;
      note_start_q <= note_start_d;
      score_done_q <= score_done_d;
      playing_q    <= (state_d != S_IDLE);
    end
  end

  // Next-state logic; KeyOut keeps the old note through FETCH/LOAD
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    key_d        = key_q;
    beats_d      = beats_q;
    ticks_d      = ticks_q;
    note_start_d = 1'b0;
    score_done_d = 1'b0;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d  = '0;
        key_d   = '0;
        beats_d = '0;
        ticks_d = '0;
        if (Start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (TimeIn != '0) begin
          key_d        = KeyIn;
          beats_d      = TimeIn;
          ticks_d      = '0;
          note_start_d = 1'b1;
          state_d      = S_PLAY;
        end else begin
          advance = 1'b1;
        end
      end
      S_PLAY: begin
        if (ticks_q == LastTick) begin
          ticks_d = '0;
          beats_d = beats_q - DataLength'(1);
          if (beats_q == DataLength'(1)) advance = 1'b1;
        end else begin
          ticks_d = ticks_q + TickBits'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Step to the next entry, wrap, or finish the score
    if (advance) begin
      if (addr_q < LastAddr) begin
        addr_d  = addr_q + AddressBits'(1);
        state_d = S_FETCH;
      end else begin
        addr_d = '0;
        if (Loop) begin
          state_d = S_FETCH;
        end else begin
          state_d      = S_IDLE;
          key_d        = '0;
          score_done_d = 1'b1;
        end
      end
    end

    // Stop overrides everything, including a Start in IDLE
    if (Stop) begin
      state_d      = S_IDLE;
      addr_d       = '0;
      key_d        = '0;
      beats_d      = '0;
      ticks_d      = '0;
      note_start_d = 1'b0;
      score_done_d = 1'b0;
    end
  end

  assign ReadOrWrite = 1'b1;
  assign Address     = addr_q;
  assign KeyOut      = key_q;
  assign Playing     = playing_q;
  assign NoteStart   = note_start_q;
  assign ScoreDone   = score_done_q;

endmodule

// File: tb/tb_music_score_player.sv
// Bench for music_score_player: models the score RAM and checks each note and
// score end against a queue of expected events.
module tb_music_score_player;

  localparam int unsigned DL = 4;
  localparam int unsigned AB = 5;

  logic          Clock, Reset, Start, Stop, Loop;
  logic          ReadOrWrite;
  logic [AB-1:0] Address;
  logic [DL-1:0] KeyIn, TimeIn, KeyOut;
  logic          Playing, NoteStart, ScoreDone;

  logic [DL-1:0] mem_key  [32];
  logic [DL-1:0] mem_time [32];

  typedef struct {
    logic          done;
    logic [DL-1:0] key;
    logic [AB-1:0] addr;
    int            hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   ns_cyc = 0;
  int   prev_hold = 0;
  bit   hold_pending = 0;
  bit   prev_done = 0;

  music_score_player #(
    .DataLength(DL), .AddressBits(AB), .ScoreLength(3), .BeatTicks(4), .TickBits(3)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Loop(Loop),
    .ReadOrWrite(ReadOrWrite), .Address(Address), .KeyIn(KeyIn), .TimeIn(TimeIn),
    .KeyOut(KeyOut), .Playing(Playing), .NoteStart(NoteStart), .ScoreDone(ScoreDone)
  );

  always #5 Clock = ~Clock;

  // Score RAM with a one-cycle registered read
  always @(posedge Clock) begin
    KeyIn  <= mem_key[Address];
    TimeIn <= mem_time[Address];
    cyc    <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic done, input int key, input int addr, input int hold);
    exp_t e;
    e.done = done;
    e.key  = DL'(key);
    e.addr = AB'(addr);
    e.hold = hold;
    return e;
  endfunction

  // Monitor: pop expected events on NoteStart / ScoreDone
  always @(negedge Clock) begin
    if (prev_done) chk("scoredone_width", 32'(ScoreDone), 0);
    prev_done = ScoreDone;
    if (NoteStart || ScoreDone) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", 32'(ScoreDone), 32'(mon_e.done));
        if (NoteStart) begin
          if (hold_pending && prev_hold > 0) chk("note_hold", 32'(cyc - ns_cyc), 32'(prev_hold));
          chk("note_key", 32'(KeyOut), 32'(mon_e.key));
          chk("note_addr", 32'(Address), 32'(mon_e.addr));
          ns_cyc       = cyc;
          prev_hold    = mon_e.hold;
          hold_pending = 1;
        end else begin
          chk("done_key", 32'(KeyOut), 0);
          chk("done_playing", 32'(Playing), 0);
          chk("done_addr", 32'(Address), 0);
          hold_pending = 0;
        end
      end
    end else if (!Playing) begin
      hold_pending = 0;
    end
  end

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge Clock); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("timeout_queue", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((Playing || exp_q.size() != 0) && n < budget) begin
      @(negedge Clock); #1;
      n++;
    end
    if (Playing || exp_q.size() != 0) chk("timeout_idle", 32'(Playing), 0);
  endtask

  task automatic pulse_start();
    Start = 1;
    @(negedge Clock); #1;
    Start = 0;
  endtask

  initial begin
    Clock = 0; Reset = 1; Start = 0; Stop = 0; Loop = 0;
    for (int i = 0; i < 32; i++) begin mem_key[i] = '0; mem_time[i] = '0; end
    mem_key[0] = 4'd5; mem_time[0] = 4'd2;
    mem_key[1] = 4'd1; mem_time[1] = 4'd1;
    mem_key[2] = 4'd9; mem_time[2] = 4'd3;

    // Reset state
    #12;
    chk("rst_keyout", 32'(KeyOut), 0);
    chk("rst_address", 32'(Address), 0);
    chk("rst_playing", 32'(Playing), 0);
    chk("rst_notestart", 32'(NoteStart), 0);
    chk("rst_scoredone", 32'(ScoreDone), 0);
    chk("rst_rw", 32'(ReadOrWrite), 1);
    @(negedge Clock); Reset = 0;
    @(negedge Clock); #1;

    // Basic playback, Loop=0
    exp_q.push_back(mk(0, 5, 0, 10));
    exp_q.push_back(mk(0, 1, 1, 6));
    exp_q.push_back(mk(0, 9, 2, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    Start = 1;
    @(posedge Clock); #1; Start = 0;
    chk("basic_playing_e1", 32'(Playing), 1);
    @(posedge Clock); #1;
    chk("basic_key_e2", 32'(KeyOut), 0);
    @(posedge Clock); #1;
    chk("basic_key_e3", 32'(KeyOut), 5);
    chk("basic_ns_e3", 32'(NoteStart), 1);
    wait_idle(200);
    chk("basic_end_key", 32'(KeyOut), 0);
    chk("basic_end_addr", 32'(Address), 0);

    // Loop: wraps back to key 5 after key 9 with no ScoreDone
    Loop = 1;
    exp_q.push_back(mk(0, 5, 0, 10));
    exp_q.push_back(mk(0, 1, 1, 6));
    exp_q.push_back(mk(0, 9, 2, 14));
    exp_q.push_back(mk(0, 5, 0, 0));
    pulse_start();
    wait_q_empty(200);
    chk("loop_playing", 32'(Playing), 1);
    Stop = 1;
    @(negedge Clock); #1; Stop = 0;
    chk("loop_stop_playing", 32'(Playing), 0);
    Loop = 0;

    // Zero-duration entry is skipped
    mem_time[1] = 4'd0;
    exp_q.push_back(mk(0, 5, 0, 12));
    exp_q.push_back(mk(0, 9, 2, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    pulse_start();
    wait_idle(200);
    mem_time[1] = 4'd1;

    // Stop three cycles into key 1, then restart
    exp_q.push_back(mk(0, 5, 0, 10));
    exp_q.push_back(mk(0, 1, 1, 0));
    pulse_start();
    wait_q_empty(200);
    repeat (2) begin @(negedge Clock); #1; end
    Stop = 1;
    @(posedge Clock); #1;
    chk("stop_key", 32'(KeyOut), 0);
    chk("stop_addr", 32'(Address), 0);
    chk("stop_playing", 32'(Playing), 0);
    chk("stop_scoredone", 32'(ScoreDone), 0);
    Stop = 0;
    @(negedge Clock); #1;
    exp_q.push_back(mk(0, 5, 0, 0));
    pulse_start();
    wait_q_empty(50);
    chk("restart_key", 32'(KeyOut), 5);
    Stop = 1;
    @(posedge Clock); #1;
    Start = 1;
    @(posedge Clock); #1;
    Start = 0; Stop = 0;
    @(posedge Clock); #1;
    chk("startstop_playing", 32'(Playing), 0);
    chk("startstop_key", 32'(KeyOut), 0);

    // Start while playing is ignored; async reset mid-note
    @(negedge Clock); #1;
    exp_q.push_back(mk(0, 5, 0, 10));
    exp_q.push_back(mk(0, 1, 1, 0));
    pulse_start();
    repeat (3) begin @(negedge Clock); #1; end
    pulse_start();
    @(negedge Clock); #1;
    pulse_start();
    wait_q_empty(100);
    @(posedge Clock); #2;
    Reset = 1;
    #1;
    chk("areset_key", 32'(KeyOut), 0);
    chk("areset_playing", 32'(Playing), 0);
    chk("areset_addr", 32'(Address), 0);
    chk("areset_ns", 32'(NoteStart), 0);
    @(negedge Clock); Reset = 0;
    repeat (5) begin @(negedge Clock); #1; end
    chk("noresume_playing", 32'(Playing), 0);
    chk("noresume_key", 32'(KeyOut), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
